nes_mem_arbiter: RTL and testbench
==================================

# nes_mem_arbiter

Shares the single external memory port (22-bit address, 8-bit data) between the NES CPU and PPU memory requesters. Latches one outstanding request per requester and grants the memory port round-robin when both are pending. Runs a request/acknowledge handshake on the memory side and returns read data to the requesters on separate registered buses. Sits between the NES core's `memory_*` signals and the external SDRAM/SRAM controller.

## Interface
Parameters:
- `ADDR_W`, 22, address width
- `DATA_W`, 8, data width

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `cpu_read`  in  1  one-cycle CPU read request strobe
- `cpu_write`  in  1  one-cycle CPU write request strobe; wins if asserted together with `cpu_read`
- `cpu_addr`  in  ADDR_W  CPU address; sampled with the strobe
- `cpu_wdata`  in  DATA_W  CPU write data; sampled with the strobe
- `cpu_rdata`  out  DATA_W  last CPU read data; holds until the next CPU read completes
- `cpu_valid`  out  1  one-cycle pulse when `cpu_rdata` updates (reads only)
- `cpu_busy`  out  1  CPU request slot occupied
- `ppu_read`  in  1  one-cycle PPU read request strobe
- `ppu_addr`  in  ADDR_W  PPU address
- `ppu_rdata`  out  DATA_W  last PPU read data
- `ppu_valid`  out  1  one-cycle pulse when `ppu_rdata` updates
- `ppu_busy`  out  1  PPU request slot occupied
- `mem_req`  out  1  memory request; held until `mem_ack`
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req` is high
- `mem_addr`  out  ADDR_W  memory address; stable while `mem_req` is high
- `mem_wdata`  out  DATA_W  memory write data; stable while `mem_req` is high
- `mem_rdata`  in  DATA_W  read data; valid in the `mem_ack` cycle
- `mem_ack`  in  1  one-cycle completion from memory
- `overrun`  out  2  sticky error flags, bit0 = CPU, bit1 = PPU

## Operation
- **Slots.** One pending slot per requester.
  - The CPU slot holds addr, wdata and we. The PPU slot holds addr.
  - A strobe with its slot free loads the slot at the clock edge and sets busy.
  - A strobe with its slot occupied is dropped and sets the matching `overrun` bit. This does not apply in the slot's completion cycle (see boundary conditions).
- **FSM states:** IDLE, CPU_XFER, PPU_XFER.
  - **IDLE:**
    - If only one slot is pending, grant it.
    - If both are pending, grant the requester not granted last. The `last_grant` register resets to CPU, so the PPU wins the first tie.
    - On a grant, register `mem_req`=1 and load `mem_addr`, `mem_we` and `mem_wdata` from the slot.
    - The PPU always uses `mem_we`=0 and `mem_wdata`=0.
  - **CPU_XFER / PPU_XFER:** hold all `mem_*` outputs. On `mem_ack`:
    - drop `mem_req`;
    - clear the granted slot;
    - for a read, register `mem_rdata` into that requester's rdata and pulse its valid;
    - update `last_grant`;
    - return to IDLE.
- `mem_ack` is ignored in IDLE.
- **Boundary conditions:**
  - **Strobe in its own slot's ack cycle:** accepted with no overrun. The slot reloads and busy stays high.
  - **Both strobes in the same cycle, both slots free:** both are latched. Arbitration follows `last_grant`.
  - **`cpu_read` and `cpu_write` together:** handled as a write. `cpu_valid` does not pulse.
  - **Reset mid-transfer:** `mem_req` drops in the next cycle and slots and flags clear. The memory controller must tolerate an abandoned request.
  - `overrun` clears only on reset.

## Timing
- **Reset values:**
  - `mem_req`, `mem_we`, `cpu_valid`, `ppu_valid`, `cpu_busy`, `ppu_busy` = 0
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `ppu_rdata` = 0
  - `overrun` = 2'b00
  - FSM = IDLE, `last_grant` = CPU
- **Request cycle N**, idle arbiter:
  - busy = 1 from N+1
  - `mem_req` = 1 from N+2
- **`mem_ack` in cycle M:**
  - `mem_req` = 0 in M+1
  - valid pulse and new rdata in M+1
  - busy = 0 in M+1, unless reloaded
- **Back-to-back transfers:** the next `mem_req` rises no earlier than M+2. There is exactly one idle cycle between transfers.
- **Minimum round trip:** with `mem_ack` in the first `mem_req` cycle (N+2), valid rises at N+3.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Single CPU read:** `cpu_read` with addr 0x00_1234 in cycle 0, memory acks 3 cycles after `mem_req` with `mem_rdata`=0x5A.
  - `mem_req` rises in cycle 2 with `mem_addr`=0x001234 and `mem_we`=0.
  - `mem_req` is high for cycles 2–5; ack in cycle 5.
  - `cpu_valid` pulses in cycle 6 with `cpu_rdata`=0x5A; `cpu_busy` is 0 in cycle 6.
- **CPU write:** `cpu_write` with addr 0x000800 and wdata 0xC3.
  - Memory sees `mem_we`=1, addr 0x000800, wdata 0xC3, all stable until ack.
  - `cpu_valid` never pulses and `cpu_rdata` is unchanged.
- **Simultaneous requests after reset:** `cpu_read` at 0x10 and `ppu_read` at 0x2000 in the same cycle, ack immediate.
  - The PPU is granted first.
  - The CPU follows with `mem_req` rising 2 cycles after the PPU ack.
  - Both valids pulse, in PPU-then-CPU order.
- **Fairness:** PPU strobes in every slot-free cycle while a CPU request is pending.
  - Grants strictly alternate PPU, CPU, PPU, …
  - Neither requester waits more than one transfer.
- **Overrun:** second `ppu_read` while `ppu_busy`=1 and no ack.
  - `overrun`=2'b10 and stays set.
  - The original PPU address completes and the second address never appears on `mem_addr`.
  - A `ppu_read` issued exactly in the ack cycle is accepted and does not set `overrun`.
- **Reset mid-transfer:** assert `reset` while `mem_req`=1.
  - The next cycle shows `mem_req`=0, both busy = 0 and `overrun`=0.
  - A late `mem_ack` after reset produces no valid pulse.

Source files
------------

// File: rtl/nes_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between the NES CPU and PPU.
// Each requester owns a single pending slot; the memory side uses a req/ack handshake.
module nes_mem_arbiter #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_valid,
    output logic              cpu_busy,
    input  logic              ppu_read,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic [DATA_W-1:0] ppu_rdata,
    output logic              ppu_valid,
    output logic              ppu_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        overrun
);

    typedef enum logic [1:0] {StIdle, StCpuXfer, StPpuXfer} state_e;

    localparam logic GrantCpu = 1'b0;
    localparam logic GrantPpu = 1'b1;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;

    logic              cpu_pend_q, cpu_pend_d;
    logic              cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic              ppu_pend_q, ppu_pend_d;
    logic [ADDR_W-1:0] ppu_addr_q, ppu_addr_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;
    logic              ppu_valid_q, ppu_valid_d;
    logic [1:0]        overrun_q, overrun_d;

    logic              cpu_strobe;
    logic              cpu_done;
    logic              ppu_done;
    logic              grant_ppu;

    assign cpu_strobe = cpu_read | cpu_write;
    assign cpu_done   = (state_q == StCpuXfer) && mem_ack;
    assign ppu_done   = (state_q == StPpuXfer) && mem_ack;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cpu_pend_d   = cpu_pend_q;
        cpu_we_d     = cpu_we_q;
        cpu_addr_d   = cpu_addr_q;
        cpu_wdata_d  = cpu_wdata_q;
        ppu_pend_d   = ppu_pend_q;
        ppu_addr_d   = ppu_addr_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_valid_d  = 1'b0;
        ppu_rdata_d  = ppu_rdata_q;
        ppu_valid_d  = 1'b0;
        overrun_d    = overrun_q;
        grant_ppu    = 1'b0;

        case (state_q)
            StIdle: begin
                // On a tie the requester that was not served last goes first.
                grant_ppu = ppu_pend_q && (!cpu_pend_q || (last_grant_q == GrantCpu));
                if (grant_ppu) begin
                    state_d     = StPpuXfer;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ppu_addr_q;
                    mem_wdata_d = '0;
                end else if (cpu_pend_q) begin
                    state_d     = StCpuXfer;
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_we_q;
                    mem_addr_d  = cpu_addr_q;
                    mem_wdata_d = cpu_wdata_q;
                end
            end
            StCpuXfer: begin
                if (mem_ack) begin
                    state_d      = StIdle;
                    mem_req_d    = 1'b0;
                    last_grant_d = GrantCpu;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                        cpu_valid_d = 1'b1;
                    end
                end
            end
            StPpuXfer: begin
                if (mem_ack) begin
                    state_d      = StIdle;
                    mem_req_d    = 1'b0;
                    last_grant_d = GrantPpu;
                    ppu_rdata_d  = mem_rdata;
                    ppu_valid_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A strobe landing in its own slot's ack cycle refills the slot instead of overrunning.
        if (cpu_done) cpu_pend_d = 1'b0;
        if (cpu_strobe) begin
            if (!cpu_pend_q || cpu_done) begin
                cpu_pend_d  = 1'b1;
                cpu_we_d    = cpu_write;
                cpu_addr_d  = cpu_addr;
                cpu_wdata_d = cpu_wdata;
            end else begin
                overrun_d[0] = 1'b1;
            end
        end

        if (ppu_done) ppu_pend_d = 1'b0;
        if (ppu_read) begin
            if (!ppu_pend_q || ppu_done) begin
                ppu_pend_d = 1'b1;
                ppu_addr_d = ppu_addr;
            end else begin
                overrun_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantCpu;
            cpu_pend_q   <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            ppu_pend_q   <= 1'b0;
            ppu_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            cpu_valid_q  <= 1'b0;
            ppu_rdata_q  <= '0;
            ppu_valid_q  <= 1'b0;
            overrun_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_we_q     <= cpu_we_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_wdata_q  <= cpu_wdata_d;
            ppu_pend_q   <= ppu_pend_d;
            ppu_addr_q   <= ppu_addr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_valid_q  <= cpu_valid_d;
            ppu_rdata_q  <= ppu_rdata_d;
            ppu_valid_q  <= ppu_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_valid = cpu_valid_q;
    assign cpu_busy  = cpu_pend_q;
    assign ppu_rdata = ppu_rdata_q;
    assign ppu_valid = ppu_valid_q;
    assign ppu_busy  = ppu_pend_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Scoreboard bench for nes_mem_arbiter: stimulus queues expected grants and read data,
// a monitor pops and compares whenever the DUT raises mem_req or a valid pulse.
module tb_nes_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [7:0]  wdata;
    } mem_txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write, ppu_read;
    logic [21:0] cpu_addr, ppu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata, ppu_rdata;
    logic        cpu_valid, cpu_busy, ppu_valid, ppu_busy;
    logic        mem_req, mem_we, mem_ack;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [1:0]  overrun;

    logic        resp_en;
    int          ack_dly;
    logic        man_ack;
    logic [7:0]  man_data;

    mem_txn_t    exp_mem[$];
    logic [7:0]  exp_cpu[$];
    logic [7:0]  exp_ppu[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    nes_mem_arbiter #(.ADDR_W(22), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
        .cpu_busy(cpu_busy),
        .ppu_read(ppu_read), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
        .ppu_valid(ppu_valid), .ppu_busy(ppu_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .overrun(overrun)
    );

    // Memory read data is a fixed function of the address so expectations can be hand-derived.
    function automatic logic [7:0] rd_fn(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks ack_dly cycles after mem_req is first seen, or manual mode.
    initial begin : responder
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'hEE;
            if (!resp_en) begin
                mem_ack   = man_ack;
                mem_rdata = man_data;
                wcnt      = 0;
            end else if (mem_req) begin
                if (wcnt >= ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_fn(mem_addr);
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : monitor
        logic     prev_req;
        mem_txn_t cur;
        mem_txn_t e;
        prev_req = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                cur = {mem_we, mem_addr, mem_wdata};
                if (exp_mem.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: addr 0x%0h, no grant expected", mem_addr);
                end else begin
                    e = exp_mem.pop_front();
                    check("grant_we", 32'(mem_we), 32'(e.we));
                    check("grant_addr", 32'(mem_addr), 32'(e.addr));
                    check("grant_wdata", 32'(mem_wdata), 32'(e.wdata));
                end
            end else if (mem_req && prev_req) begin
                check("req_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(cur));
            end
            prev_req = mem_req;
            if (cpu_valid) begin
                if (exp_cpu.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cpu_valid: rdata 0x%0h", cpu_rdata);
                end else begin
                    check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu.pop_front()));
                end
            end
            if (ppu_valid) begin
                if (exp_ppu.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ppu_valid: rdata 0x%0h", ppu_rdata);
                end else begin
                    check("ppu_rdata", 32'(ppu_rdata), 32'(exp_ppu.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        ppu_read  = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        tick();
        tick();
        while ((mem_req || cpu_busy || ppu_busy) && c < 100) begin
            tick();
            c++;
        end
        if (c >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: arbiter still busy after %0d cycles", name, c);
        end
        tick();
    endtask

    task automatic push_rd(input logic is_ppu, input logic [21:0] a, input logic [7:0] d);
        exp_mem.push_back({1'b0, a, 8'h00});
        if (is_ppu) exp_ppu.push_back(d);
        else exp_cpu.push_back(d);
    endtask

    initial begin : stim
        int nc, np;
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; ppu_read = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; ppu_addr = '0;
        resp_en = 1'b1; ack_dly = 0; man_ack = 1'b0; man_data = 8'h00;

        // Reset values
        tick(); tick(); reset = 1'b0;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'({cpu_busy, ppu_busy}), 0);
        check("rst_valid", 32'({cpu_valid, ppu_valid}), 0);
        check("rst_rdata", 32'({cpu_rdata, ppu_rdata}), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Single CPU read, ack three cycles after mem_req
        ack_dly = 3;
        tick(); cpu_read = 1'b1; cpu_addr = 22'h001234; cpu_wdata = 8'h00;
        push_rd(1'b0, 22'h001234, 8'h5A);
        tick(); check("rd_c1_busy", 32'(cpu_busy), 1); check("rd_c1_req", 32'(mem_req), 0);
        tick(); check("rd_c2_req", 32'(mem_req), 1); check("rd_c2_addr", 32'(mem_addr), 32'h1234);
        tick(); check("rd_c3_req", 32'(mem_req), 1);
        tick(); check("rd_c4_req", 32'(mem_req), 1);
        tick(); check("rd_c5_req", 32'(mem_req), 1); check("rd_c5_valid", 32'(cpu_valid), 0);
        tick(); check("rd_c6_req", 32'(mem_req), 0); check("rd_c6_valid", 32'(cpu_valid), 1);
        check("rd_c6_rdata", 32'(cpu_rdata), 32'h5A); check("rd_c6_busy", 32'(cpu_busy), 0);
        wait_idle("rd");

        // CPU write, then read+write together (must act as a write)
        ack_dly = 2;
        tick(); cpu_write = 1'b1; cpu_addr = 22'h000800; cpu_wdata = 8'hC3;
        exp_mem.push_back({1'b1, 22'h000800, 8'hC3});
        wait_idle("wr");
        check("wr_rdata_kept", 32'(cpu_rdata), 32'h5A);
        tick(); cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 22'h000801; cpu_wdata = 8'h11;
        exp_mem.push_back({1'b1, 22'h000801, 8'h11});
        wait_idle("rdwr");
        check("rdwr_rdata_kept", 32'(cpu_rdata), 32'h5A);

        // Simultaneous requests after reset: PPU first, CPU two cycles after PPU ack
        do_reset();
        ack_dly = 0;
        tick(); cpu_read = 1'b1; cpu_addr = 22'h000010; cpu_wdata = 8'h00;
        ppu_read = 1'b1; ppu_addr = 22'h002000;
        push_rd(1'b1, 22'h002000, 8'h5C);
        push_rd(1'b0, 22'h000010, 8'h6C);
        tick();
        tick(); check("sim_c2_addr", 32'(mem_addr), 32'h2000);
        tick(); check("sim_c3_req", 32'(mem_req), 0); check("sim_c3_pvalid", 32'(ppu_valid), 1);
        tick(); check("sim_c4_req", 32'(mem_req), 1); check("sim_c4_addr", 32'(mem_addr), 32'h10);
        tick(); check("sim_c5_cvalid", 32'(cpu_valid), 1);
        wait_idle("sim");

        // Fairness: each side re-strobes whenever its slot is free; grants must alternate
        ack_dly = 1;
        nc = 0;
        np = 0;
        for (int c = 0; c < 300 && (nc < 4 || np < 4); c++) begin
            tick();
            if (!cpu_busy && nc < 4) begin
                cpu_read = 1'b1; cpu_addr = 22'h000100 + 22'(nc);
                push_rd(1'b0, 22'h000100 + 22'(nc), rd_fn(22'h000100 + 22'(nc)));
                nc++;
            end
            if (c >= 1 && !ppu_busy && np < 4) begin
                ppu_read = 1'b1; ppu_addr = 22'h003000 + 22'(np);
                push_rd(1'b1, 22'h003000 + 22'(np), rd_fn(22'h003000 + 22'(np)));
                np++;
            end
        end
        wait_idle("fair");

        // PPU strobe in its ack cycle is accepted; a strobe while busy overruns
        do_reset();
        ack_dly = 2;
        tick(); ppu_read = 1'b1; ppu_addr = 22'h002200;
        push_rd(1'b1, 22'h002200, 8'h5E);
        tick(); tick(); tick();
        tick(); ppu_read = 1'b1; ppu_addr = 22'h002300;
        push_rd(1'b1, 22'h002300, 8'h5F);
        tick(); check("ack_strobe_busy", 32'(ppu_busy), 1);
        check("ack_strobe_overrun", 32'(overrun), 0); check("ack_strobe_valid", 32'(ppu_valid), 1);
        tick(); check("ovr_c6_addr", 32'(mem_addr), 32'h2300);
        ppu_read = 1'b1; ppu_addr = 22'h002F00;
        tick(); check("ovr_set", 32'(overrun), 2);
        wait_idle("ovr");
        check("ovr_sticky", 32'(overrun), 2);

        // Tie after a PPU grant: CPU wins
        ack_dly = 0;
        tick(); cpu_read = 1'b1; cpu_addr = 22'h000040; ppu_read = 1'b1; ppu_addr = 22'h002400;
        push_rd(1'b0, 22'h000040, 8'h3C);
        push_rd(1'b1, 22'h002400, 8'h58);
        wait_idle("tie2");

        // Reset mid-transfer with an abandoned request and a late ack
        resp_en = 1'b0;
        tick(); cpu_read = 1'b1; cpu_addr = 22'h000055; ppu_read = 1'b1; ppu_addr = 22'h002500;
        exp_mem.push_back({1'b0, 22'h000055, 8'h00});
        tick();
        tick(); check("mid_c2_req", 32'(mem_req), 1); check("mid_c2_ovr", 32'(overrun), 2);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        check("mid_req_drop", 32'(mem_req), 0);
        check("mid_busy_clr", 32'({cpu_busy, ppu_busy}), 0);
        check("mid_ovr_clr", 32'(overrun), 0);
        tick(); man_ack = 1'b1; man_data = 8'h99;
        tick(); man_ack = 1'b0;
        tick(); check("late_ack_novalid", 32'({cpu_valid, ppu_valid}), 0);
        check("late_ack_noreq", 32'(mem_req), 0);
        tick(); tick(); tick();
        resp_en = 1'b1;

        check("exp_mem_drained", 32'(exp_mem.size()), 0);
        check("exp_cpu_drained", 32'(exp_cpu.size()), 0);
        check("exp_ppu_drained", 32'(exp_ppu.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
